axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, 12, word-address width; memory depth = 2^MEM_AW 32-bit words.
REQ-002 SHALL have one clock and a synchronous, active-high reset: ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-003 SHALL have AR inputs: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1.
REQ-004 SHALL have output arready (1): AR address accepted.
REQ-005 SHALL have R outputs: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1.
REQ-006 SHALL have input rready (1).
REQ-007 SHALL have AW inputs: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1.
REQ-008 SHALL have output awready (1).
REQ-009 SHALL have W inputs: wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1.
REQ-010 SHALL have output wready (1).
REQ-011 SHALL have B outputs: bid 4, bresp 2, bvalid 1.
REQ-012 SHALL have input bready (1).
REQ-013 SHALL accept and ignore inputs arlock/awlock 2, arcache/awcache 4 and arprot/awprot 3; wid and wlast SHALL be ignored functionally.

Function
REQ-014 SHALL be a single-outstanding AXI3 slave with states IDLE, RD, WR, WRESP.
REQ-015 In IDLE, arready/awready SHALL be high for the granted channel only; the handshake moves the FSM to RD or WR on the next cycle.
REQ-016 If arvalid and awvalid are both high in IDLE, grant SHALL go to the channel not granted last (round-robin bit); the bit resets to "write last", so read wins first.
REQ-017 On acceptance SHALL latch id, addr, len, size and burst, and clear the beat counter.
REQ-018 Word index SHALL be addr[MEM_AW+1:2].
REQ-019 Beat address SHALL advance by (1<<size) for INCR (2'b01) and stay constant for FIXED (2'b00); WRAP (2'b10) SHALL be treated as INCR.
REQ-020 RD: rvalid SHALL rise one cycle after the AR handshake, with rdata = mem[index], rid = latched id and rresp = OKAY.
REQ-021 RD: rvalid, rdata and rlast SHALL hold stable until rready.
REQ-022 RD: each R handshake SHALL advance the beat; the next beat is valid in the following cycle (one idle cycle between beats is allowed; max throughput 1 beat per 2 cycles).
REQ-023 RD: rlast SHALL be high when beat == len; the R handshake on that beat returns to IDLE.
REQ-024 WR: wready SHALL be high; each W handshake SHALL write the wdata bytes enabled by wstrb into mem[index], then advance the beat (1 beat/cycle).
REQ-025 WR: the beat counter SHALL decide burst end (beat == len), independent of wlast; that handshake goes to WRESP.
REQ-026 WRESP: bvalid SHALL be high with bid = latched awid and bresp = OKAY; on bready return to IDLE.
REQ-027 A beat counter over 256 beats is impossible (len ≤ 255); the address SHALL wrap modulo 2^32.
REQ-028 Writes take effect at the handshake edge; a read of the same word issued later SHALL return the new data.

Reset
REQ-029 When rst is high at a clock edge: state IDLE; arready, awready, wready, rvalid, rlast and bvalid SHALL be 0; rid, bid, rdata and rresp SHALL be 0; the round-robin bit resets to "write last".
REQ-030 Reset mid-burst SHALL abandon the burst without a response; memory contents SHALL NOT be reset.

Configuration
REQ-031 Macro AXI_SLV_RANGE_CHECK_EN defined: any beat with addr[31:MEM_AW+2] != 0 SHALL be out of range.
REQ-032 Out-of-range read beat: rdata = 0, rresp = DECERR (2'b11).
REQ-033 Out-of-range write beat: the write is suppressed, and the burst's bresp SHALL be DECERR if any beat was out of range.
REQ-034 Macro undefined: the upper address bits SHALL be ignored (aliasing); the response is always OKAY.

Verification
REQ-035 Single write then read: awaddr 0x10, len 0, wdata 0xDEADBEEF, wstrb 0xF -> bresp 0, bid = awid; then a read of 0x10 -> rdata 0xDEADBEEF, rlast 1.
REQ-036 Byte strobe: write 0x11223344 to 0x20, then wstrb 0x2 with wdata 0x0000AA00 -> a read returns 0x1122AA44.
REQ-037 INCR read burst, len 3 at 0x0, with rready toggling every cycle -> 4 beats in order, data held while stalled, rlast only on beat 3.
REQ-038 Simultaneous arvalid/awvalid right after reset -> read granted first, write granted next; two consecutive collisions alternate.
REQ-039 With AXI_SLV_RANGE_CHECK_EN and MEM_AW 12: read 0x4000 -> rresp 2'b11, rdata 0; without the macro -> data from 0x0000.
REQ-040 rst asserted during beat 2 of a len-7 write burst -> all valid/ready 0 next cycle and no bvalid; beats 0-1 remain in memory.

Source files
------------

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI3 slave in front of a 2^MEM_AW x 32-bit SRAM.
// Define AXI_SLV_RANGE_CHECK_EN to answer DECERR for beats above the memory.
module axi_sram_slave #(
  parameter int MEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,

  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,

  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,

  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,

  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic        err_q, err_d;
  logic        last_wr_q, last_wr_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q;

  logic [31:0] mem [2**MEM_AW];

  logic              grant_rd, grant_wr;
  logic              rd_load, wr_en;
  logic [31:0]       rd_addr, next_addr;
  logic              rd_oor, wr_oor;
  logic [MEM_AW-1:0] rd_idx, wr_idx;

  // Round-robin only matters on a collision; a lone request always wins.
  assign grant_rd  = arvalid & (~awvalid | last_wr_q);
  assign grant_wr  = awvalid & ~grant_rd;
  assign rd_addr   = (state_q == IDLE) ? araddr : addr_q;
  assign rd_idx    = rd_addr[MEM_AW+1:2];
  assign wr_idx    = addr_q[MEM_AW+1:2];
  assign next_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + (32'd1 << size_q);

`ifdef AXI_SLV_RANGE_CHECK_EN
  assign rd_oor = |rd_addr[31:MEM_AW+2];
  assign wr_oor = |addr_q[31:MEM_AW+2];
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{arlock, awlock, arcache, awcache, arprot, awprot,
                           wid, wlast, rd_addr};

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    last_wr_d = last_wr_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rd_load   = 1'b0;
    wr_en     = 1'b0;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;

    case (state_q)
      IDLE: begin
        arready = grant_rd;
        awready = grant_wr;
        if (grant_rd) begin
          state_d   = RD;
          id_d      = arid;
          addr_d    = araddr;
          len_d     = arlen;
          size_d    = arsize;
          burst_d   = arburst;
          beat_d    = 8'd0;
          last_wr_d = 1'b0;
          // First beat is fetched at the handshake edge straight from araddr.
          rd_load   = 1'b1;
          rvalid_d  = 1'b1;
          rlast_d   = (arlen == 8'd0);
          rresp_d   = rd_oor ? RESP_DECERR : RESP_OKAY;
        end else if (grant_wr) begin
          state_d   = WR;
          id_d      = awid;
          addr_d    = awaddr;
          len_d     = awlen;
          size_d    = awsize;
          burst_d   = awburst;
          beat_d    = 8'd0;
          err_d     = 1'b0;
          last_wr_d = 1'b1;
        end
      end

      RD: begin
        if (rvalid_q) begin
          if (rready) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            beat_d   = beat_q + 8'd1;
            addr_d   = next_addr;
            if (rlast_q) state_d = IDLE;
          end
        end else begin
          rd_load  = 1'b1;
          rvalid_d = 1'b1;
          rlast_d  = (beat_q == len_q);
          rresp_d  = rd_oor ? RESP_DECERR : RESP_OKAY;
        end
      end

      WR: begin
        wready = 1'b1;
        if (wvalid) begin
          wr_en  = 1'b1;
          err_d  = err_q | wr_oor;
          beat_d = beat_q + 8'd1;
          addr_d = next_addr;
          // Burst end comes from the beat count; wlast is not trusted.
          if (beat_q == len_q) state_d = WRESP;
        end
      end

      WRESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the block above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      last_wr_q <= last_wr_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      if (rd_load) rdata_q <= rd_oor ? 32'd0 : mem[rd_idx];
    end
  end

  // NOTE: the memory array has no reset; contents survive rst, and a reset
  // edge that coincides with a write beat blocks that write.
  always_ff @(posedge clk) begin
    if (wr_en && !rst && !wr_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rlast  = rlast_q;
  assign rresp  = rresp_q;
  assign rid    = id_q;
  assign bid    = id_q;
  assign bresp  = err_q ? RESP_DECERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: table of single-beat transfers plus
// hand-written bursts, collisions, range checks and mid-burst reset.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    logic ok = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    check("ar_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    logic ok = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    check("aw_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb);
    logic ok = 1'b0;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (wready) begin ok = 1'b1; break; end
    end
    check("w_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic b_wait(input string name, input logic [3:0] id, input logic [1:0] resp);
    logic ok = 1'b0;
    bready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1'b1; break; end
    end
    check({name, "_bvalid"}, 32'(ok), 32'd1);
    check({name, "_bid"}, 32'(bid), 32'(id));
    check({name, "_bresp"}, 32'(bresp), 32'(resp));
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic r_beat(input string name, input logic [3:0] id, input logic [31:0] exp_data,
                        input logic exp_last, input logic [1:0] exp_resp, output int waited);
    logic ok = 1'b0;
    waited = 0;
    rready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      waited++;
      if (rvalid) begin ok = 1'b1; break; end
    end
    check({name, "_rvalid"}, 32'(ok), 32'd1);
    check({name, "_rdata"}, rdata, exp_data);
    check({name, "_rlast"}, 32'(rlast), 32'(exp_last));
    check({name, "_rresp"}, 32'(rresp), 32'(exp_resp));
    check({name, "_rid"}, 32'(rid), 32'(id));
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          waited;
    int          beat;
    logic        stalled;
    logic        saw_b;
    logic        ok;
    logic [31:0] held;
    logic [3:0]  tid;

    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    arlock = '0; awlock = '0; arcache = '0; awcache = '0; arprot = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0000_AA00, 4'h2, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h1122_AA44};
    vecs[5]  = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0024, 32'h0000_0000, 4'h9, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h00FF_FF00};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 4'hF, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 32'hA5A5_A5A5};

    // Reset values while rst is held high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rid",     32'(rid),     32'd0);
    check("rst_bid",     32'(bid),     32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Collisions right after reset: read first, then write.
    arid = 4'd1; araddr = 32'h10; arlen = 8'd0; arvalid = 1'b1;
    awid = 4'd2; awaddr = 32'h30; awlen = 8'd0; awvalid = 1'b1;
    @(negedge clk);
    check("coll1_arready", 32'(arready), 32'd1);
    check("coll1_awready", 32'(awready), 32'd0);
    @(posedge clk); #1;
    arid = 4'd4; araddr = 32'h30;
    rready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1'b1; break; end
    end
    check("coll1_rvalid", 32'(ok), 32'd1);
    check("coll1_rid", 32'(rid), 32'd1);
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check("coll2_arready", 32'(arready), 32'd0);
    check("coll2_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    w_beat(32'h3030_3030, 4'hF);
    b_wait("coll2", 4'd2, 2'b00);
    ok = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    check("coll3_arready", 32'(ok), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    r_beat("coll3", 4'd4, 32'h3030_3030, 1'b1, 2'b00, waited);

    // Single-beat table.
    for (int i = 0; i < 11; i++) begin
      tid = 4'(i);
      if (vecs[i].is_wr) begin
        aw_send(tid, vecs[i].addr, 8'd0, 2'b01);
        w_beat(vecs[i].data, vecs[i].strb);
        b_wait($sformatf("vec%0d", i), tid, 2'b00);
      end else begin
        ar_send(tid, vecs[i].addr, 8'd0, 2'b01);
        r_beat($sformatf("vec%0d", i), tid, vecs[i].exp, 1'b1, 2'b00, waited);
        check($sformatf("vec%0d_latency", i), 32'(waited), 32'd1);
      end
    end

    // FIXED write burst: both beats hit 0x40, second wins.
    aw_send(4'd9, 32'h40, 8'd1, 2'b00);
    w_beat(32'h1111_1111, 4'hF);
    w_beat(32'h2222_2222, 4'hF);
    b_wait("fixed", 4'd9, 2'b00);
    ar_send(4'd9, 32'h40, 8'd0, 2'b01);
    r_beat("fixed", 4'd9, 32'h2222_2222, 1'b1, 2'b00, waited);

    // INCR write burst of 4 words at 0x0, then read it back with rready toggling.
    aw_send(4'd5, 32'h0, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'hC0DE_0000 + 32'(i), 4'hF);
    b_wait("incr_wr", 4'd5, 2'b00);
    ar_send(4'd7, 32'h0, 8'd3, 2'b01);
    beat = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
      rready = cyc[0];
      @(negedge clk);
      if (stalled) begin
        check("burst_hold_valid", 32'(rvalid), 32'd1);
        check("burst_hold_data", rdata, held);
      end
      if (rvalid) begin
        check($sformatf("burst_rlast%0d", beat), 32'(rlast), 32'(beat == 3));
        check("burst_rid", 32'(rid), 32'd7);
        if (rready) begin
          check($sformatf("burst_data%0d", beat), rdata, 32'hC0DE_0000 + 32'(beat));
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = rdata;
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    check("burst_beats", 32'(beat), 32'd4);

    // Upper address bits: decode error or aliasing depending on the build.
    ar_send(4'd6, 32'h4000, 8'd0, 2'b01);
`ifdef AXI_SLV_RANGE_CHECK_EN
    r_beat("oor_rd", 4'd6, 32'h0, 1'b1, 2'b11, waited);
    aw_send(4'd10, 32'h4010, 8'd0, 2'b01);
    w_beat(32'h1234_5678, 4'hF);
    b_wait("oor_wr", 4'd10, 2'b11);
    ar_send(4'd11, 32'h10, 8'd0, 2'b01);
    r_beat("oor_wr_chk", 4'd11, 32'hDEAD_BEEF, 1'b1, 2'b00, waited);
`else
    r_beat("alias_rd", 4'd6, 32'hC0DE_0000, 1'b1, 2'b00, waited);
    aw_send(4'd10, 32'h4010, 8'd0, 2'b01);
    w_beat(32'h1234_5678, 4'hF);
    b_wait("alias_wr", 4'd10, 2'b00);
    ar_send(4'd11, 32'h10, 8'd0, 2'b01);
    r_beat("alias_wr_chk", 4'd11, 32'h1234_5678, 1'b1, 2'b00, waited);
`endif

    // Reset during beat 2 of a len-7 write burst.
    aw_send(4'd3, 32'h100, 8'd7, 2'b01);
    w_beat(32'hB0B0_0000, 4'hF);
    w_beat(32'hB0B0_0001, 4'hF);
    wdata = 32'hB0B0_0002; wstrb = 4'hF; wvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    check("mid_arready", 32'(arready), 32'd0);
    check("mid_awready", 32'(awready), 32'd0);
    check("mid_wready",  32'(wready),  32'd0);
    check("mid_rvalid",  32'(rvalid),  32'd0);
    check("mid_rlast",   32'(rlast),   32'd0);
    check("mid_bvalid",  32'(bvalid),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bvalid) saw_b = 1'b1;
    end
    check("mid_no_bvalid", 32'(saw_b), 32'd0);
    @(posedge clk); #1;
    ar_send(4'd12, 32'h100, 8'd1, 2'b01);
    r_beat("mid_beat0", 4'd12, 32'hB0B0_0000, 1'b0, 2'b00, waited);
    r_beat("mid_beat1", 4'd12, 32'hB0B0_0001, 1'b1, 2'b00, waited);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
